// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one product or quotient bit per cycle,
// start/done handshake, fixed XLEN+2 cycle latency for every operation.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [6:0]      opcode,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic [CW-1:0]     cnt_reg;
    logic [2:0]        op_reg;
    logic              neg_a_reg, neg_b_reg, div_zero_reg, ovf_reg;
    logic [XLEN-1:0]   mag_b_reg, rs1_reg, result_reg;
    logic [2*XLEN-1:0] acc_reg;

    logic              accept;
    logic              sign_a, sign_b, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic              q_bit;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot, rem, fix_val;

    assign accept = (state_reg == IDLE) && start &&
                    (opcode == 7'b0110011) && (funct7 == 7'b0000001);

    // Signed-operand decode: MULH/DIV/REM both, MULHSU rs1 only.
    assign sign_a = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b110);
    assign sign_b = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    assign neg_a  = sign_a && rs1[XLEN-1];
    assign neg_b  = sign_b && rs2[XLEN-1];
    assign mag_a  = neg_a ? (~rs1 + 1'b1) : rs1;
    assign mag_b  = neg_b ? (~rs2 + 1'b1) : rs2;

    // Both paths start with |rs1| in the low half; multiplication is commutative,
    // so |rs2| is the multiplicand for multiply and the divisor for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} +
                   (acc_reg[0] ? {1'b0, mag_b_reg} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_reg[XLEN-1:1]};

        // Restoring step: shifted partial remainder carries one guard bit.
        rem_sh   = acc_reg[2*XLEN-1:XLEN-1];
        q_bit    = (rem_sh >= {1'b0, mag_b_reg});
        rem_sub  = rem_sh[XLEN-1:0] - mag_b_reg;
        div_next = {(q_bit ? rem_sub : rem_sh[XLEN-1:0]), acc_reg[XLEN-2:0], q_bit};
    end

    always_comb begin
        prod_fix = (neg_a_reg ^ neg_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
        quot     = acc_reg[XLEN-1:0];
        rem      = acc_reg[2*XLEN-1:XLEN];
        fix_val  = '0;
        unique case (op_reg)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (div_zero_reg)             fix_val = '1;
                else if (ovf_reg)             fix_val = rs1_reg;
                else if (neg_a_reg ^ neg_b_reg) fix_val = ~quot + 1'b1;
                else                          fix_val = quot;
            end
            default: begin
                if (div_zero_reg)   fix_val = rs1_reg;
                else if (ovf_reg)   fix_val = '0;
                else if (neg_a_reg) fix_val = ~rem + 1'b1;
                else                fix_val = rem;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt_reg == CW'(XLEN - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            op_reg       <= '0;
            neg_a_reg    <= 1'b0;
            neg_b_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            mag_b_reg    <= '0;
            rs1_reg      <= '0;
            acc_reg      <= '0;
            result_reg   <= '0;
        end else begin
            if (accept) begin
                cnt_reg      <= '0;
                op_reg       <= funct3;
                neg_a_reg    <= neg_a;
                neg_b_reg    <= neg_b;
                div_zero_reg <= (rs2 == '0);
                ovf_reg      <= sign_b && funct3[2] && (rs1 == MIN_NEG) && (rs2 == '1);
                mag_b_reg    <= mag_b;
                rs1_reg      <= rs1;
                acc_reg      <= {{XLEN{1'b0}}, mag_a};
            end else if (state_reg == CALC) begin
                cnt_reg <= cnt_reg + CW'(1);
                acc_reg <= op_reg[2] ? div_next : mul_next;
            end
            if (state_reg == FIX) result_reg <= fix_val;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 and XLEN=64: latency, handshake,
// corner cases, async reset/abort and randomised operations against a reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start32 = 1'b0, start64 = 1'b0;
    logic [6:0]  opcode = '0, funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic        busy32, done32, busy64, done64;
    logic [31:0] result32;
    logic [63:0] result64;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] q32[$];
    logic [63:0] q64[$];

    typedef struct {
        logic [2:0]  f3;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .opcode(opcode), .funct7(funct7),
        .funct3(funct3), .rs1(rs1[31:0]), .rs2(rs2[31:0]),
        .busy(busy32), .done(done32), .result(result32)
    );

    muldiv_unit #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .start(start64), .opcode(opcode), .funct7(funct7),
        .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .busy(busy64), .done(done64), .result(result64)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_op(input int w, input logic [2:0] f3,
                                           input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0] m, mn, a, b, ret;
        logic sa, sb;
        logic signed [129:0] ea, eb, p, one;
        m   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        mn  = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
        a   = a_in & m;
        b   = b_in & m;
        one = 130'sd1;
        sa  = (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6) && ((a & mn) != 0);
        sb  = (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) && ((b & mn) != 0);
        ea  = {66'b0, a};
        eb  = {66'b0, b};
        if (sa) ea = ea - (one << w);
        if (sb) eb = eb - (one << w);
        if (!f3[2]) begin
            p = ea * eb;
            if (f3 == 3'd0) ret = p[63:0] & m;
            else            ret = 64'(p >> w) & m;
        end else if (b == 0) begin
            ret = f3[1] ? a : m;
        end else if ((f3 == 3'd4 || f3 == 3'd6) && a == mn && b == m) begin
            ret = f3[1] ? 64'd0 : mn;
        end else begin
            p   = f3[1] ? (ea % eb) : (ea / eb);
            ret = p[63:0] & m;
        end
        return ret;
    endfunction

    function automatic logic [63:0] sx32(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

    function automatic logic [63:0] pick(input bit wide);
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = wide ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
            default: v = {$urandom, $urandom};
        endcase
        return wide ? v : (v & 64'hFFFF_FFFF);
    endfunction

    // Scoreboard: every done pops the oldest expected result for that instance.
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) check_val("sb32_spurious", {63'b0, done32}, 64'd0);
            else                 check_val("res32", {32'b0, result32}, q32.pop_front());
        end
        if (done64) begin
            if (q64.size() == 0) check_val("sb64_spurious", {63'b0, done64}, 64'd0);
            else                 check_val("res64", result64, q64.pop_front());
        end
    end

    task automatic run_op(input bit wide, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input bit hold);
        int w;
        int e;
        logic d, bz;
        w = wide ? 64 : 32;
        @(negedge clk);
        opcode = 7'b0110011;
        funct7 = 7'b0000001;
        funct3 = f3;
        rs1    = a;
        rs2    = b;
        if (wide) begin start64 = 1'b1; q64.push_back(exp); end
        else      begin start32 = 1'b1; q32.push_back(exp); end
        @(posedge clk);
        for (e = 0; e <= w + 5; e++) begin
            @(negedge clk);
            if (!hold) begin start32 = 1'b0; start64 = 1'b0; end
            if (hold && e == 3) begin
                rs1    = {$urandom, $urandom};
                rs2    = {$urandom, $urandom};
                funct3 = ~f3;
            end
            bz = wide ? busy64 : busy32;
            d  = wide ? done64 : done32;
            if (e == 0) check_val("busy_rise", {63'b0, bz}, 64'd1);
            if (d) break;
        end
        check_val("latency", 64'(e), 64'(w + 1));
        $display("op xlen=%0d f3=%0d a=%h b=%h exp=%h done_after_edge=%0d hold=%0d",
                 w, f3, a, b, exp, e, hold);
        @(negedge clk);
        d  = wide ? done64 : done32;
        bz = wide ? busy64 : busy32;
        check_val("done_width", {63'b0, d}, 64'd0);
        check_val("busy_fall", {63'b0, bz}, 64'd0);
        start32 = 1'b0;
        start64 = 1'b0;
        if (hold) begin
            @(negedge clk);
            bz = wide ? busy64 : busy32;
            check_val("no_requeue", {63'b0, bz}, 64'd0);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic bad;

        tbl[0]  = '{3'b000, 64'd7,          64'hFFFF_FFFD, 64'hFFFF_FFEB};
        tbl[1]  = '{3'b001, 64'h8000_0000,  64'h8000_0000, 64'h4000_0000};
        tbl[2]  = '{3'b011, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFE};
        tbl[3]  = '{3'b010, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 64'hFFFF_FFFF};
        tbl[4]  = '{3'b100, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFD};
        tbl[5]  = '{3'b110, 64'hFFFF_FFF9,  64'd2,         64'hFFFF_FFFF};
        tbl[6]  = '{3'b101, 64'hFFFF_FFF9,  64'd2,         64'h7FFF_FFFC};
        tbl[7]  = '{3'b111, 64'd100,        64'd7,         64'd2};
        tbl[8]  = '{3'b100, 64'd5,          64'd0,         64'hFFFF_FFFF};
        tbl[9]  = '{3'b111, 64'd5,          64'd0,         64'd5};
        tbl[10] = '{3'b100, 64'h8000_0000,  64'hFFFF_FFFF, 64'h8000_0000};
        tbl[11] = '{3'b110, 64'h8000_0000,  64'hFFFF_FFFF, 64'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy32", {63'b0, busy32}, 64'd0);
        check_val("rst_done32", {63'b0, done32}, 64'd0);
        check_val("rst_res32", {32'b0, result32}, 64'd0);
        check_val("rst_busy64", {63'b0, busy64}, 64'd0);
        check_val("rst_res64", result64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-M opcodes / funct7 never start the unit
        opcode = 7'b0010011; funct7 = 7'b0000001; start32 = 1'b1; start64 = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            bad |= busy32 | done32 | busy64 | done64;
        end
        check_val("ignore_opcode", {63'b0, bad}, 64'd0);
        opcode = 7'b0110011; funct7 = 7'b0000000;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bad |= busy32 | done32 | busy64 | done64;
        end
        check_val("ignore_funct7", {63'b0, bad}, 64'd0);
        start32 = 1'b0; start64 = 1'b0;

        // Directed vectors, XLEN=32 then sign-extended at XLEN=64
        foreach (tbl[i]) run_op(1'b0, tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0);
        foreach (tbl[i])
            run_op(1'b1, tbl[i].f3, sx32(tbl[i].a), sx32(tbl[i].b),
                   ref_op(64, tbl[i].f3, sx32(tbl[i].a), sx32(tbl[i].b)), 1'b0);
        run_op(1'b1, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b0);
        run_op(1'b1, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);

        // start held through the whole op including DONE; operands change after accept
        run_op(1'b0, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 1'b1);

        // Asynchronous reset asserted mid-cycle clears outputs immediately
        run_op(1'b0, 3'b111, 64'd100, 64'd7, 64'd2, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_rst_res32", {32'b0, result32}, 64'd0);
        check_val("async_rst_busy32", {63'b0, busy32}, 64'd0);
        check_val("async_rst_done32", {63'b0, done32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort a DIV at edge 10: no done, result cleared, next op correct
        run_op(1'b0, 3'b111, 64'd100, 64'd7, 64'd2, 1'b0);
        @(negedge clk);
        funct3 = 3'b100; rs1 = 64'hFFFF_FFF9; rs2 = 64'd2; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("abort_busy32", {63'b0, busy32}, 64'd0);
        check_val("abort_res32", {32'b0, result32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            bad |= done32 | busy32;
        end
        check_val("abort_nodone", {63'b0, bad}, 64'd0);
        run_op(1'b0, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 1'b0);

        // Randomised operations against the reference model
        for (int k = 0; k < 24; k++) begin
            bit wide;
            logic [2:0] f3;
            logic [63:0] a, b;
            wide = (k % 2) == 1;
            f3   = 3'($urandom_range(0, 7));
            a    = pick(wide);
            b    = pick(wide);
            run_op(wide, f3, a, b, ref_op(wide ? 64 : 32, f3, a, b), 1'b0);
        end

        repeat (5) @(negedge clk);
        check_val("sb32_drain", 64'(q32.size()), 64'd0);
        check_val("sb64_drain", 64'(q64.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
